// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write initiator.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int DIV_W      = 8;  // wide enough for CLK_DIV up to 255
  localparam int IDX_W      = 4;  // indexes FRAME_BITS bits

  // Frame field positions (frame is shifted out LSB-first)
  localparam int WR_BIT   = 0;
  localparam int ADDR_LSB = 1;
  localparam int ADDR_MSB = 7;
  localparam int DATA_LSB = 8;
  localparam int DATA_MSB = 15;

  // Peripheral register map
  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_e;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Pack the request fields into transmit order.
  function automatic frame_t build_frame(input logic              wr,
                                         input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data);
    frame_t f;
    f                    = '0;
    f[WR_BIT]            = wr;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:DATA_LSB] = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer: counts clk cycles within one SPI phase and flags its last cycle.
module spi_phase_timer
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic phase_end
);

  logic [DIV_W-1:0] div_cnt;

  // Counter restarts from zero whenever the owner changes state or is idle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Last cycle of the current phase.
  always_comb begin
    phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends one 16-bit LSB-first write frame per request.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              cs_n,
  output logic              sclk,
  output logic              copi
);

  // The peripheral's two-flop synchroniser needs at least four clocks per phase.
  if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be within 4..255");
  end

  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(FRAME_BITS - 1);

  spi_state_e       state, next_state;
  frame_t           frame_q, frame_d;
  logic [IDX_W-1:0] bit_idx, bit_idx_d;
  logic             cs_n_d, sclk_d, copi_d, done_d;
  logic             phase_end;
  logic             timer_clear;

  // Phase counter is held at zero in IDLE and restarts on every state change.
  assign timer_clear = (state == IDLE) || (next_state != state);

  spi_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .phase_end (phase_end)
  );

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      frame_q <= '0;
      bit_idx <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      copi    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      frame_q <= frame_d;
      bit_idx <= bit_idx_d;
      cs_n    <= cs_n_d;
      sclk    <= sclk_d;
      copi    <= copi_d;
      done    <= done_d;
    end
  end

  // Next-state sequencing: one phase per state visit, 16 HIGH and 15 LOW phases.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)     next_state = SETUP;
      SETUP:   if (phase_end) next_state = HIGH;
      HIGH:    if (phase_end) next_state = (bit_idx == LAST_BIT) ? HOLD : LOW;
      LOW:     if (phase_end) next_state = HIGH;
      HOLD:    if (phase_end) next_state = GAP;
      GAP:     if (phase_end) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Next values for the pins and shift datapath; COPI only moves at CS fall or SCLK fall.
  always_comb begin
    frame_d   = frame_q;
    bit_idx_d = bit_idx;
    cs_n_d    = cs_n;
    sclk_d    = sclk;
    copi_d    = copi;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
        if (start) begin
          frame_d   = build_frame(wr, addr, wdata);
          cs_n_d    = 1'b0;
          copi_d    = wr;
          bit_idx_d = '0;
        end
      end
      SETUP: begin
        if (phase_end) sclk_d = 1'b1;
      end
      HIGH: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          if (bit_idx != LAST_BIT) begin
            bit_idx_d = bit_idx + IDX_W'(1);
            copi_d    = frame_q[bit_idx + IDX_W'(1)];
          end
        end
      end
      LOW: begin
        if (phase_end) sclk_d = 1'b1;
      end
      HOLD: begin
        if (phase_end) begin
          cs_n_d = 1'b1;
          copi_d = 1'b0;
        end
      end
      GAP: begin
        if (phase_end) done_d = 1'b1;
      end
      default: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
      end
    endcase
  end

  // Requests are only taken in IDLE.
  always_comb begin
    ready = (state == IDLE);
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed self-checking bench for spi_controller with a behavioural peripheral.
module tb_spi_controller;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, wr;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       ready, done, cs_n, sclk, copi;

  logic       start8, wr8;
  logic [6:0] addr8;
  logic [7:0] wdata8;
  logic       ready8, done8, cs_n8, sclk8, copi8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_controller #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .cs_n(cs_n), .sclk(sclk), .copi(copi)
  );

  spi_controller #(.CLK_DIV(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .wr(wr8), .addr(addr8), .wdata(wdata8),
    .ready(ready8), .done(done8), .cs_n(cs_n8), .sclk(sclk8), .copi(copi8)
  );

  // Monitor plus peripheral model: samples COPI at SCLK rises, commits on CS rise.
  int          rise_cnt   = 0;
  int          cs_low_cnt = 0;
  int          done_cnt   = 0;
  int          done8_cnt  = 0;
  int          cs8_run    = 0;
  int          last_gap8  = 0;
  logic [15:0] cap        = '0;
  logic [15:0] pshift     = '0;
  int          pcnt       = 0;
  logic        prev_sclk  = 1'b0;
  logic        prev_cs    = 1'b1;
  logic        prev_cs8   = 1'b1;
  logic [7:0]  regs [5]   = '{default: 8'h00};

  always @(negedge clk) begin
    int a_i;
    if (!cs_n && prev_cs) pcnt = 0;
    if (sclk && !prev_sclk) begin
      rise_cnt++;
      cap = {copi, cap[15:1]};
      if (!cs_n) begin
        pshift = {copi, pshift[15:1]};
        pcnt++;
      end
    end
    if (cs_n && !prev_cs) begin
      a_i = int'(pshift[7:1]);
      if (pcnt == 16 && pshift[0] && a_i < 5) regs[a_i] = pshift[15:8];
    end
    if (!cs_n) cs_low_cnt++;
    if (done)  done_cnt++;
    if (done8) done8_cnt++;
    if (cs_n8) cs8_run++;
    else if (prev_cs8) begin
      last_gap8 = cs8_run;
      cs8_run   = 0;
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
    prev_cs8  = cs_n8;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(ready), 32'd1);
    wr = w; addr = a; wdata = d; start = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    start = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wait_done(input int budget, output int edge_no);
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        edge_no = cyc;
        break;
      end
    end
    check("done_seen", 32'(edge_no >= 0), 32'd1);
  endtask

  // One complete frame with latency and SCLK-count checks.
  task automatic do_frame(input logic w, input logic [6:0] a, input logic [7:0] d);
    int acc, de, r0, dc0;
    r0  = rise_cnt;
    dc0 = done_cnt;
    send(w, a, d, acc);
    wait_done(300, de);
    repeat (3) @(negedge clk);
    check("frame_latency", 32'(de - acc), 32'd136);
    check("frame_rises", 32'(rise_cnt - r0), 32'd16);
    check("frame_done_cnt", 32'(done_cnt - dc0), 32'd1);
  endtask

  logic [7:0] exp_regs [5];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, de, r0, dc0, cl0, rises, d8_0, d8_1, k;
    logic [6:0] tbl_a [5];
    logic [7:0] tbl_d [5];
    logic       ps;

    rst = 1'b1; start = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    start8 = 1'b0; wr8 = 1'b0; addr8 = '0; wdata8 = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_copi", 32'(copi), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_ready8", 32'(ready8), 32'd1);
    rst = 1'b0;

    // 1: single write, bit pattern, CS low time, latency
    r0 = rise_cnt; dc0 = done_cnt; cl0 = cs_low_cnt;
    send(1'b1, REG_PWM_DUTY, 8'hA5, acc);
    wait_done(300, de);
    check("t1_ready_with_done", 32'(ready), 32'd1);
    repeat (3) @(negedge clk);
    check("t1_latency", 32'(de - acc), 32'd136);
    check("t1_rises", 32'(rise_cnt - r0), 32'd16);
    check("t1_bits", 32'(cap), 32'h0000_A509);
    check("t1_cs_low", 32'(cs_low_cnt - cl0), 32'd132);
    check("t1_done_cnt", 32'(done_cnt - dc0), 32'd1);
    check("t1_cs_idle", 32'(cs_n), 32'd1);

    // 2: loopback writes into each register
    tbl_a = '{REG_EN_OUT_7_0, REG_EN_OUT_15_8, REG_EN_PWM_7_0, REG_EN_PWM_15_8, REG_PWM_DUTY};
    tbl_d = '{8'hFF, 8'h0F, 8'h81, 8'h3C, 8'h80};
    for (int i = 0; i < 5; i++) begin
      do_frame(1'b1, tbl_a[i], tbl_d[i]);
      check($sformatf("t2_reg%0d", i), 32'(regs[i]), 32'(tbl_d[i]));
    end
    exp_regs = '{8'hFF, 8'h0F, 8'h81, 8'h3C, 8'h80};

    // 3: read-flag frame transmitted unchanged, discarded; out-of-map address ignored
    do_frame(1'b0, REG_PWM_DUTY, 8'h55);
    check("t3_bits_wr0", 32'(cap), 32'h0000_5508);
    check("t3_duty_kept", 32'(regs[4]), 32'h80);
    do_frame(1'b1, 7'h05, 8'h12);
    for (int i = 0; i < 5; i++) check($sformatf("t3_reg%0d", i), 32'(regs[i]), 32'(exp_regs[i]));

    // 4: second start mid-frame is ignored
    r0 = rise_cnt; dc0 = done_cnt;
    send(1'b1, REG_EN_OUT_15_8, 8'hC3, acc);
    repeat (9) @(negedge clk);
    check("t4_busy", 32'(ready), 32'd0);
    wr = 1'b1; addr = REG_EN_OUT_7_0; wdata = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    wait_done(300, de);
    repeat (200) @(negedge clk);
    check("t4_latency", 32'(de - acc), 32'd136);
    check("t4_rises", 32'(rise_cnt - r0), 32'd16);
    check("t4_bits", 32'(cap), 32'h0000_C303);
    check("t4_done_cnt", 32'(done_cnt - dc0), 32'd1);
    check("t4_reg1", 32'(regs[1]), 32'hC3);
    check("t4_reg0", 32'(regs[0]), 32'hFF);
    exp_regs[1] = 8'hC3;

    // 5: reset during the 7th HIGH phase aborts the frame
    send(1'b1, REG_EN_OUT_7_0, 8'h00, acc);
    rises = 0; ps = sclk;
    for (int i = 0; i < 200 && rises < 7; i++) begin
      @(negedge clk);
      if (sclk && !ps) rises++;
      ps = sclk;
    end
    check("t5_reached_7th_high", 32'(rises), 32'd7);
    dc0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t5_cs_n", 32'(cs_n), 32'd1);
    check("t5_sclk", 32'(sclk), 32'd0);
    check("t5_copi", 32'(copi), 32'd0);
    check("t5_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - dc0), 32'd0);
    for (int i = 0; i < 5; i++) check($sformatf("t5_reg%0d", i), 32'(regs[i]), 32'(exp_regs[i]));
    do_frame(1'b1, REG_EN_PWM_15_8, 8'h99);
    check("t5_after_reg3", 32'(regs[3]), 32'h99);

    // 6: back-to-back frames on the CLK_DIV=8 instance
    @(negedge clk);
    wr8 = 1'b1; addr8 = REG_EN_PWM_7_0; wdata8 = 8'h33; start8 = 1'b1;
    acc = cyc + 1;
    d8_0 = -1; d8_1 = -1; k = 0;
    for (int i = 0; i < 800 && k < 2; i++) begin
      @(negedge clk);
      if (done8) begin
        if (k == 0) d8_0 = cyc;
        else        d8_1 = cyc;
        k++;
      end
    end
    start8 = 1'b0; wr8 = 1'b0; addr8 = '0; wdata8 = '0;
    repeat (300) @(negedge clk);
    check("t6_two_dones_seen", 32'(k), 32'd2);
    check("t6_first_latency", 32'(d8_0 - acc), 32'd272);
    check("t6_done_spacing", 32'(d8_1 - d8_0), 32'd273);
    check("t6_cs_gap", 32'(last_gap8), 32'd9);
    check("t6_done_total", 32'(done8_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
